mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the single synchronous memory port between the control unit's instruction-fetch path (iFetch state) and the datapath's load/store path. Accepts one request at a time and drives the memory through a fixed issue/wait/response sequence. Returns read data and a one-cycle completion pulse to whichever requester was granted. The control unit holds its state (PC_HOLD) until the fetch completion pulse arrives.

## Interface
- AW, 64: address width.
- DW, 64: data width; fetch uses low 32 bits of returned data.
- WAIT_CYCLES, 1: memory read latency in cycles, legal range 1..15.

- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held high until if_valid.
- if_addr  in  AW  fetch address; stable while if_req is high.
- if_gnt  out  1  one-cycle pulse: fetch accepted (ISSUE cycle).
- if_valid  out  1  one-cycle pulse: fetch complete, if_rdata valid.
- if_rdata  out  32  fetched instruction.
- ls_req  in  1  load/store request; held high until ls_valid.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  AW  data address.
- ls_wdata  in  DW  store data.
- ls_gnt  out  1  one-cycle pulse: load/store accepted.
- ls_valid  out  1  one-cycle pulse: load/store complete.
- ls_rdata  out  DW  load data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid WAIT_CYCLES cycles after the mem_en cycle.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - With no request, stay in IDLE.
  - With any request, select the winner, latch address/we/wdata into mem_* registers, and go to ISSUE.
- ISSUE (1 cycle):
  - mem_en=1, mem_we=latched we.
  - Winner's gnt=1.
  - Load wait counter with WAIT_CYCLES and go to WAIT.
- WAIT:
  - Decrement the counter each cycle; mem_en=0.
  - In the cycle where the counter equals 1, register mem_rdata into the winner's rdata and go to RESP.
- RESP (1 cycle):
  - Winner's valid=1.
  - Return to IDLE.
  - Requests are not sampled in RESP.
- Stores follow the same sequence.
  - ls_valid still pulses.
  - ls_rdata is not updated.
- rdata outputs hold their value until the next completion for the same requester.
- A requester dropping req after acceptance does not abort the transaction; valid still pulses.
- Requests asserted during ISSUE/WAIT/RESP are ignored until IDLE.
- Reset values:
  - All outputs 0, including if_rdata, ls_rdata and mem_* buses.
  - Counter 0; last-grant flag = fetch.
- Reset asserted mid-transaction clears state asynchronously: mem_en/mem_we drop immediately, and no valid is issued.

## Timing
- Request sampled high in IDLE at cycle T:
  - ISSUE at T+1, with gnt and mem_en.
  - WAIT from T+2 to T+1+WAIT_CYCLES.
  - RESP/valid at T+2+WAIT_CYCLES.
- Latency from request to valid: WAIT_CYCLES+2 cycles.
- Throughput: one transaction per WAIT_CYCLES+3 cycles for back-to-back requests, because IDLE always lasts at least one cycle.
- Simultaneous if_req and ls_req in IDLE: resolved per Configuration.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - When both requests are high in IDLE, grant the requester not granted last.
  - The last-grant flag updates in ISSUE and resets to fetch, so load/store wins the first conflict.
- Not defined:
  - ls_req always wins a conflict (fixed priority); the last-grant flag is absent.
- With a single requester, behaviour is identical in both builds.

## Test plan
- Fetch read, WAIT_CYCLES=1, if_addr=0x40, memory returns 0xB5000002 one cycle after mem_en:
  - if_gnt at T+1.
  - if_valid at T+3 with if_rdata=0xB5000002.
  - busy high T+1..T+3.
- Store, ls_we=1, ls_addr=0x100, ls_wdata=0xDEADBEEF:
  - mem_en=mem_we=1 for exactly one cycle with that address/data.
  - ls_valid at T+3.
  - ls_rdata unchanged.
- Both requests held high for three transactions:
  - Fixed-priority build: grants LS, LS, LS.
  - ARB_ROUND_ROBIN_EN build: grants LS, IF, LS.
  - Each valid reaches only its owner.
- WAIT_CYCLES=4, load with memory data 0x1234 valid only in the fourth cycle after mem_en:
  - ls_rdata=0x1234.
  - ls_valid at T+6.
- reset pulled low during WAIT of a fetch:
  - Outputs clear immediately; no if_valid.
  - After release with if_req still high, a fresh ISSUE occurs one cycle later.
- if_req dropped the cycle after if_gnt:
  - if_valid still pulses at T+2+WAIT_CYCLES.
  - Then IDLE with busy=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single synchronous memory port between instruction fetch and load/store.
// Optional build macro ARB_ROUND_ROBIN_EN: round-robin on conflicts (default: load/store priority).
module mem_port_arbiter #(
   parameter int AW          = 64,
   parameter int DW          = 64,
   parameter int WAIT_CYCLES = 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_valid,
   output logic [31:0]   if_rdata,
   input  logic          ls_req,
   input  logic          ls_we,
   input  logic [AW-1:0] ls_addr,
   input  logic [DW-1:0] ls_wdata,
   output logic          ls_gnt,
   output logic          ls_valid,
   output logic [DW-1:0] ls_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          win_ls_q, win_ls_d;
   logic          win_we_q, win_we_d;
   logic          mem_en_q, mem_en_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic          if_gnt_q, if_gnt_d;
   logic          ls_gnt_q, ls_gnt_d;
   logic          if_valid_q, if_valid_d;
   logic          ls_valid_q, ls_valid_d;
   logic [31:0]   if_rdata_q, if_rdata_d;
   logic [DW-1:0] ls_rdata_q, ls_rdata_d;
   logic          busy_q, busy_d;
   logic          pick_ls;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_ls_q, last_ls_d;

   // On a conflict the requester that was not served last wins; flag resets to fetch.
   assign pick_ls = ls_req & (~if_req | ~last_ls_q);

   always_comb begin
      last_ls_d = last_ls_q;
      if (state_q == S_ISSUE) begin
         last_ls_d = win_ls_q;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         last_ls_q <= 1'b0;
      end else begin
         last_ls_q <= last_ls_d;
      end
   end
`else
   assign pick_ls = ls_req;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      win_ls_d    = win_ls_q;
      win_we_d    = win_we_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_gnt_d    = 1'b0;
      ls_gnt_d    = 1'b0;
      if_valid_d  = 1'b0;
      ls_valid_d  = 1'b0;
      if_rdata_d  = if_rdata_q;
      ls_rdata_d  = ls_rdata_q;

      unique case (state_q)
         S_IDLE: begin
            // Strobes and grants are computed here so they appear registered in ISSUE.
            if (if_req || ls_req) begin
               state_d     = S_ISSUE;
               win_ls_d    = pick_ls;
               win_we_d    = pick_ls & ls_we;
               mem_en_d    = 1'b1;
               mem_we_d    = pick_ls & ls_we;
               mem_addr_d  = pick_ls ? ls_addr : if_addr;
               mem_wdata_d = pick_ls ? ls_wdata : '0;
               if_gnt_d    = ~pick_ls;
               ls_gnt_d    = pick_ls;
            end
         end
         S_ISSUE: begin
            cnt_d   = WAIT_INIT;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = S_RESP;
               if (win_ls_q) begin
                  ls_valid_d = 1'b1;
                  if (!win_we_q) begin
                     ls_rdata_d = mem_rdata;
                  end
               end else begin
                  if_valid_d = 1'b1;
                  if_rdata_d = mem_rdata[31:0];
               end
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         win_ls_q    <= 1'b0;
         win_we_q    <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_gnt_q    <= 1'b0;
         ls_gnt_q    <= 1'b0;
         if_valid_q  <= 1'b0;
         ls_valid_q  <= 1'b0;
         if_rdata_q  <= '0;
         ls_rdata_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         win_ls_q    <= win_ls_d;
         win_we_q    <= win_we_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_gnt_q    <= if_gnt_d;
         ls_gnt_q    <= ls_gnt_d;
         if_valid_q  <= if_valid_d;
         ls_valid_q  <= ls_valid_d;
         if_rdata_q  <= if_rdata_d;
         ls_rdata_q  <= ls_rdata_d;
         busy_q      <= busy_d;
      end
   end

   assign if_gnt    = if_gnt_q;
   assign if_valid  = if_valid_q;
   assign if_rdata  = if_rdata_q;
   assign ls_gnt    = ls_gnt_q;
   assign ls_valid  = ls_valid_q;
   assign ls_rdata  = ls_rdata_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;

endmodule
